vscr_multi: RTL and testbench
=============================

Name: vscr_multi

Overview:
- Parametrised successor to the single-source VSCR block: a Vector Status and Control Register shared by NUM_SAT_SRC execution units (PU, VALU, VCFX, ...).
- Implements architectural semantics:
  - sticky SAT accumulation (OR of all sources, never overwritten by a source);
  - NJ control bit output to the FP datapath;
  - mtvscr write with a writable-bit mask;
  - mfvscr read through a READ_LAT-deep pipeline carrying the RF target tag.
- Sits between the execution units and the vector register file writeback.

Parameters:
- DATA_W, 32, VSCR width (bits numbered 0..DATA_W-1, big-endian).
- NUM_SAT_SRC, 3, number of saturation-reporting units (1..8).
- TAG_W, 5, RF target register index width.
- READ_LAT, 1, mfvscr read latency in cycles (1..4).
- SAT_BIT, 31, bit index of SAT.
- NJ_BIT, 15, bit index of NJ.
- WR_MASK, 32'h0001_0001, writable bits, big-endian mask (bits 15 and 31); all other bits are stored and read as 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_VSCRReadEnable  in  1  mfvscr issue
- in_VSCRTargetRegister  in  TAG_W  destination VR of mfvscr
- in_VSCRWriteEnable  in  1  mtvscr issue
- in_VSCR  in  DATA_W  mtvscr data
- sat_en  in  NUM_SAT_SRC  per-source valid
- sat_data  in  NUM_SAT_SRC  per-source saturation flag
- VSCR_RFTargetRegEn  out  1  read result valid to RF
- VSCR_RFTargetRegister  out  TAG_W  read result tag
- out_VSCR  out  DATA_W  read result data
- vscr_nj  out  1  current NJ (registered VSCR_reg[NJ_BIT])
- vscr_sat  out  1  current SAT (registered VSCR_reg[SAT_BIT])

Behaviour:
- Reset: synchronous on rst=1 at clk edge; reset dominates every other input.
  - Values: VSCR_reg=0; all read-pipeline stages invalid with tag 0 and data 0; out_VSCR=0, VSCR_RFTargetRegEn=0, VSCR_RFTargetRegister=0, vscr_nj=0, vscr_sat=0.
  - Reset mid-operation discards in-flight reads; no RegEn pulse is emitted for them.
- sat_hit = OR over i of (sat_en[i] & sat_data[i]). A source with sat_en=1, sat_data=0 has no effect; SAT is never cleared by a source.
- Register update, next VSCR_reg:
  - in_VSCRWriteEnable=1: (in_VSCR & WR_MASK) with bit SAT_BIT additionally ORed with sat_hit. A same-cycle saturation survives mtvscr.
  - else: VSCR_reg with bit SAT_BIT ORed with sat_hit.
  - Non-WR_MASK bits are always 0.
- Read and write are independent. Simultaneous read+write is legal; the read samples the pre-update VSCR_reg (old value), unless VSCR_RD_BYPASS_EN is defined.
- Read pipeline: shift register of READ_LAT stages of {valid, tag, data}.
  - Stage 0 captures {in_VSCRReadEnable, in_VSCRTargetRegister, sampled value} every cycle.
  - Invalid stages carry tag 0.
  - The last stage drives VSCR_RFTargetRegEn and VSCR_RFTargetRegister.
  - out_VSCR updates only when the last stage is valid and otherwise holds its last read value.
  - Back-to-back reads every cycle are supported: full throughput, one result per cycle, in order.
- Latency: read issued in cycle N → RegEn=1 in cycle N+READ_LAT, for exactly 1 cycle per read.
- vscr_nj and vscr_sat reflect VSCR_reg directly, 1 cycle after the updating edge.
- Elaboration-time checks:
  - SAT_BIT and NJ_BIT < DATA_W, and SAT_BIT != NJ_BIT.
  - READ_LAT in 1..4; violation is a fatal error.

Optional Feature:
- VSCR_RD_BYPASS_EN
  - Defined: the read sample is the next VSCR_reg value, so a same-cycle mtvscr or saturation is visible to the mfvscr issued that cycle.
  - Undefined: the read sample is the current VSCR_reg (old value).
  - Latency is identical in both modes.

Decomposition:
- Package vscr_pkg holds: SAT_BIT/NJ_BIT defaults, WR_MASK default, TAG_W default, and a struct typedef vscr_rd_stage_t {valid, tag, data}.
- Sub-module vscr_rd_pipe: parametrised READ_LAT shift register of vscr_rd_stage_t with hold-on-invalid output data. The top module holds VSCR_reg, sticky-SAT logic, and write masking.

Test Plan:
- Reset, then mtvscr in_VSCR=32'hFFFF_FFFF → VSCR_reg=32'h0001_0001, vscr_nj=1, vscr_sat=1. Then mfvscr tag 5'd7 → out_VSCR=32'h0001_0001, tag 7, RegEn high 1 cycle after READ_LAT cycles.
- Sticky SAT:
  - src1 sat_en=1, sat_data=1 → vscr_sat=1.
  - Then 10 cycles of sat_en=1, sat_data=0 on all sources → vscr_sat stays 1.
  - Then mtvscr 32'h0 → SAT=0.
- Same-cycle mtvscr 32'h0 plus src0 sat_hit → VSCR_reg=32'h0000_0001.
- Same-cycle mfvscr and mtvscr, with old value 32'h0 and new value 32'h0001_0000:
  - without VSCR_RD_BYPASS_EN → out_VSCR=32'h0;
  - with VSCR_RD_BYPASS_EN → out_VSCR=32'h0001_0000.
- READ_LAT=3, mfvscr on 4 consecutive cycles with tags 1,2,3,4 → RegEn high for 4 consecutive cycles starting 3 cycles later, tags 1,2,3,4 in order. Then RegEn=0 and tag=0, while out_VSCR holds.
- rst asserted 1 cycle after a READ_LAT=3 read → no RegEn pulse afterwards; all outputs 0.

Source files
------------

// File: rtl/vscr_pkg.sv
// Shared defaults and read-pipeline stage type for the multi-source VSCR.
// Bit positions are big-endian: architectural bit b lives at vector index DATA_W-1-b.
package vscr_pkg;

    localparam int          VSCR_DATA_W  = 32;
    localparam int          VSCR_TAG_W   = 5;
    localparam int          VSCR_SAT_BIT = 31;
    localparam int          VSCR_NJ_BIT  = 15;
    localparam logic [31:0] VSCR_WR_MASK = 32'h0001_0001;

    // One mfvscr pipeline slot at the default widths; wider builds pass their own type.
    typedef struct packed {
        logic                   valid;
        logic [VSCR_TAG_W-1:0]  tag;
        logic [VSCR_DATA_W-1:0] data;
    } vscr_rd_stage_t;

    function automatic int be_index(input int data_w, input int be_bit);
        return data_w - 1 - be_bit;
    endfunction

endpackage

// File: rtl/vscr_rd_pipe.sv
// READ_LAT-deep mfvscr result pipeline; the last stage keeps its data while idle
// so the RF-facing data bus holds the most recent read result.
module vscr_rd_pipe
    import vscr_pkg::*;
#(
    parameter int  READ_LAT = 1,
    parameter type stage_t  = vscr_rd_stage_t
) (
    input  logic   clk,
    input  logic   rst,
    input  stage_t in_stage,
    output stage_t out_stage
);

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $fatal(1, "vscr_rd_pipe: READ_LAT must be in 1..4");
    end

    // Empty slots are forced to all-zero so an idle pipe never shows a stale tag.
    stage_t cap;
    assign cap = in_stage.valid ? in_stage : '0;

    for (genvar g = 0; g < READ_LAT; g++) begin : g_stage
        stage_t src;
        stage_t q;

        if (g == 0) begin : g_first
            assign src = cap;
        end else begin : g_rest
            assign src = g_stage[g-1].q;
        end

        if (g == READ_LAT - 1) begin : g_last
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else begin
                    q.valid <= src.valid;
                    q.tag   <= src.tag;
                    if (src.valid) begin
                        q.data <= src.data;
                    end
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else begin
                    q <= src;
                end
            end
        end
    end

    assign out_stage = g_stage[READ_LAT-1].q;

endmodule

// File: rtl/vscr_multi.sv
// Vector Status and Control Register shared by NUM_SAT_SRC execution units.
// Optional build macro VSCR_RD_BYPASS_EN: mfvscr samples the next VSCR value instead of the current one.
module vscr_multi
    import vscr_pkg::*;
#(
    parameter int                DATA_W      = VSCR_DATA_W,
    parameter int                NUM_SAT_SRC = 3,
    parameter int                TAG_W       = VSCR_TAG_W,
    parameter int                READ_LAT    = 1,
    parameter int                SAT_BIT     = VSCR_SAT_BIT,
    parameter int                NJ_BIT      = VSCR_NJ_BIT,
    parameter logic [DATA_W-1:0] WR_MASK     = DATA_W'(VSCR_WR_MASK)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_VSCRReadEnable,
    input  logic [TAG_W-1:0]       in_VSCRTargetRegister,
    input  logic                   in_VSCRWriteEnable,
    input  logic [DATA_W-1:0]      in_VSCR,
    input  logic [NUM_SAT_SRC-1:0] sat_en,
    input  logic [NUM_SAT_SRC-1:0] sat_data,
    output logic                   VSCR_RFTargetRegEn,
    output logic [TAG_W-1:0]       VSCR_RFTargetRegister,
    output logic [DATA_W-1:0]      out_VSCR,
    output logic                   vscr_nj,
    output logic                   vscr_sat
);

    if (SAT_BIT < 0 || SAT_BIT >= DATA_W || NJ_BIT < 0 || NJ_BIT >= DATA_W) begin : g_bad_bit
        $fatal(1, "vscr_multi: SAT_BIT and NJ_BIT must lie inside DATA_W");
    end
    if (SAT_BIT == NJ_BIT) begin : g_same_bit
        $fatal(1, "vscr_multi: SAT_BIT and NJ_BIT must differ");
    end
    if (NUM_SAT_SRC < 1 || NUM_SAT_SRC > 8) begin : g_bad_src
        $fatal(1, "vscr_multi: NUM_SAT_SRC must be in 1..8");
    end

    localparam int SAT_IDX = be_index(DATA_W, SAT_BIT);
    localparam int NJ_IDX  = be_index(DATA_W, NJ_BIT);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } rd_stage_t;

    logic [DATA_W-1:0] vscr_reg;
    logic [DATA_W-1:0] vscr_nxt;
    logic [DATA_W-1:0] rd_sample;
    logic              sat_hit;

    assign sat_hit = |(sat_en & sat_data);

    // SAT is sticky: sources only ever set it, and a same-cycle hit survives mtvscr.
    always_comb begin
        vscr_nxt = in_VSCRWriteEnable ? (in_VSCR & WR_MASK) : vscr_reg;
        vscr_nxt[SAT_IDX] = vscr_nxt[SAT_IDX] | sat_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vscr_reg <= '0;
        end else begin
            vscr_reg <= vscr_nxt;
        end
    end

`ifdef VSCR_RD_BYPASS_EN
    assign rd_sample = vscr_nxt;
`else
    assign rd_sample = vscr_reg;
`endif

    // Read interface: valid-only, no back-pressure. in_VSCRReadEnable=1 issues one read;
    // READ_LAT cycles later VSCR_RFTargetRegEn is high for exactly one cycle with the tag.
    rd_stage_t rd_in;
    rd_stage_t rd_out;

    assign rd_in.valid = in_VSCRReadEnable;
    assign rd_in.tag   = in_VSCRTargetRegister;
    assign rd_in.data  = rd_sample;

    vscr_rd_pipe #(
        .READ_LAT (READ_LAT),
        .stage_t  (rd_stage_t)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_stage  (rd_in),
        .out_stage (rd_out)
    );

    assign VSCR_RFTargetRegEn    = rd_out.valid;
    assign VSCR_RFTargetRegister = rd_out.tag;
    assign out_VSCR              = rd_out.data;
    assign vscr_nj               = vscr_reg[NJ_IDX];
    assign vscr_sat              = vscr_reg[SAT_IDX];

endmodule

// File: tb/tb_vscr_multi.sv
// Bench for vscr_multi: a READ_LAT=1 and a READ_LAT=3 instance share one stimulus stream.
// Honours VSCR_RD_BYPASS_EN when the bundle is built with it.
module tb_vscr_multi;

`ifdef VSCR_RD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] MASK = 32'h0001_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        re;
    logic [4:0]  tag_in;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  sat_en;
    logic [2:0]  sat_data;

    logic        regen1, regen3;
    logic [4:0]  tag1, tag3;
    logic [31:0] out1, out3;
    logic        nj1, nj3, sat1, sat3;

    always #5 clk = ~clk;

    vscr_multi dut1 (
        .clk(clk), .rst(rst),
        .in_VSCRReadEnable(re), .in_VSCRTargetRegister(tag_in),
        .in_VSCRWriteEnable(we), .in_VSCR(wdata),
        .sat_en(sat_en), .sat_data(sat_data),
        .VSCR_RFTargetRegEn(regen1), .VSCR_RFTargetRegister(tag1),
        .out_VSCR(out1), .vscr_nj(nj1), .vscr_sat(sat1)
    );

    vscr_multi #(.READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_VSCRReadEnable(re), .in_VSCRTargetRegister(tag_in),
        .in_VSCRWriteEnable(we), .in_VSCR(wdata),
        .sat_en(sat_en), .sat_data(sat_data),
        .VSCR_RFTargetRegEn(regen3), .VSCR_RFTargetRegister(tag3),
        .out_VSCR(out3), .vscr_nj(nj3), .vscr_sat(sat3)
    );

    // Scoreboard entries: {due cycle[15:0], tag[4:0], data[31:0]}
    logic [52:0] exp_q1[$];
    logic [52:0] exp_q3[$];
    logic [31:0] last1, last3;
    logic [31:0] model_reg;
    int          cyc;
    int          n_vec;
    int          n_bad;

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  tg;
        logic [2:0]  se;
        logic [2:0]  sd;
        logic        enj;
        logic        esat;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic w, input logic [31:0] wd,
                                input logic rd, input logic [4:0] tg,
                                input logic [2:0] se, input logic [2:0] sd,
                                input logic enj, input logic esat, input logic [31:0] erd);
        vec_t v;
        v.rst = r; v.we = w; v.wd = wd; v.re = rd; v.tg = tg;
        v.se = se; v.sd = sd; v.enj = enj; v.esat = esat; v.erd = erd;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_rd(input string nm, input logic en, input logic [4:0] tg,
                          input logic [31:0] data, input logic due,
                          input logic [4:0] etag, input logic [31:0] edata);
        chk({nm, ".regen"}, 32'(en), 32'(due));
        chk({nm, ".tag"}, 32'(tg), due ? 32'(etag) : 32'd0);
        chk({nm, ".data"}, data, edata);
    endtask

    function automatic logic [31:0] model_next(input logic w, input logic [31:0] wd,
                                               input logic [2:0] se, input logic [2:0] sd);
        logic [31:0] n;
        n = w ? (wd & MASK) : model_reg;
        n[0] = n[0] | (|(se & sd));
        return n;
    endfunction

    task automatic step(input logic r, input logic w, input logic [31:0] wd,
                        input logic rd, input logic [4:0] tg,
                        input logic [2:0] se, input logic [2:0] sd,
                        input logic enj, input logic esat, input logic [31:0] erd);
        logic [52:0] item;
        logic        due;
        rst = r; we = w; wdata = wd; re = rd; tag_in = tg; sat_en = se; sat_data = sd;
        @(posedge clk);
        cyc++;
        if (r) begin
            model_reg = 32'd0;
            exp_q1.delete();
            exp_q3.delete();
            last1 = 32'd0;
            last3 = 32'd0;
        end else begin
            model_reg = model_next(w, wd, se, sd);
            if (rd) begin
                exp_q1.push_back({16'(cyc), tg, erd});
                exp_q3.push_back({16'(cyc + 2), tg, erd});
            end
        end
        #1;
        chk("nj1", 32'(nj1), 32'(enj));
        chk("sat1", 32'(sat1), 32'(esat));
        chk("nj3", 32'(nj3), 32'(enj));
        chk("sat3", 32'(sat3), 32'(esat));

        item = '0;
        due = (exp_q1.size() > 0) && (exp_q1[0][52:37] == 16'(cyc));
        if (due) begin
            item = exp_q1.pop_front();
            last1 = item[31:0];
        end
        chk_rd("rl1", regen1, tag1, out1, due, item[36:32], last1);

        item = '0;
        due = (exp_q3.size() > 0) && (exp_q3[0][52:37] == 16'(cyc));
        if (due) begin
            item = exp_q3.pop_front();
            last3 = item[31:0];
        end
        chk_rd("rl3", regen3, tag3, out3, due, item[36:32], last3);
    endtask

    task automatic idle(input int n, input logic enj, input logic esat);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 3'd0, 3'd0, enj, esat, 32'd0);
        end
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0;
        last1 = 32'd0; last3 = 32'd0; model_reg = 32'd0;
        rst = 1'b1; re = 1'b0; tag_in = 5'd0; we = 1'b0; wdata = 32'd0;
        sat_en = 3'd0; sat_data = 3'd0;

        //  rst we  wdata           re tag    sen     sdat    nj sat rd
        add(1, 0, 32'h0,           0, 5'd0,  3'b000, 3'b000, 0, 0, 32'h0);
        add(1, 1, 32'hFFFF_FFFF,   1, 5'd7,  3'b111, 3'b111, 0, 0, 32'h0);
        add(0, 1, 32'hFFFF_FFFF,   0, 5'd0,  3'b000, 3'b000, 1, 1, 32'h0);
        add(0, 0, 32'h0,           1, 5'd7,  3'b000, 3'b000, 1, 1, 32'h0001_0001);
        add(0, 1, 32'h0,           0, 5'd0,  3'b000, 3'b000, 0, 0, 32'h0);
        add(0, 0, 32'h0,           0, 5'd0,  3'b010, 3'b010, 0, 1, 32'h0);
        for (int i = 0; i < 10; i++) begin
            add(0, 0, 32'h0,       0, 5'd0,  3'b111, 3'b000, 0, 1, 32'h0);
        end
        add(0, 1, 32'h0,           0, 5'd0,  3'b000, 3'b000, 0, 0, 32'h0);
        add(0, 1, 32'h0,           0, 5'd0,  3'b001, 3'b001, 0, 1, 32'h0);
        add(0, 0, 32'h0,           1, 5'd3,  3'b000, 3'b000, 0, 1, 32'h0000_0001);
        add(0, 1, 32'h0,           0, 5'd0,  3'b000, 3'b000, 0, 0, 32'h0);
        add(0, 0, 32'h0,           0, 5'd0,  3'b000, 3'b111, 0, 0, 32'h0);
        add(0, 1, 32'h0001_0000,   1, 5'd9,  3'b000, 3'b000, 1, 0,
            BYP ? 32'h0001_0000 : 32'h0);
        add(0, 0, 32'h0,           1, 5'd10, 3'b100, 3'b100, 1, 1,
            BYP ? 32'h0001_0001 : 32'h0001_0000);
        add(0, 1, 32'hFFFE_FFFE,   0, 5'd0,  3'b111, 3'b000, 0, 0, 32'h0);
        add(0, 0, 32'h0,           1, 5'd11, 3'b000, 3'b000, 0, 0, 32'h0);
        add(0, 1, 32'h8001_8000,   0, 5'd0,  3'b000, 3'b000, 1, 0, 32'h0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].tg,
                 tbl[i].se, tbl[i].sd, tbl[i].enj, tbl[i].esat, tbl[i].erd);
        end
        idle(3, 1'b1, 1'b0);

        // Back-to-back reads, tags 1..4; RL3 results land on 4 consecutive cycles then hold.
        for (int t = 1; t <= 4; t++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1, 5'(t), 3'd0, 3'd0, 1'b1, 1'b0, 32'h0001_0000);
        end
        idle(5, 1'b1, 1'b0);

        // Reset one cycle after a read: the RL3 result must never appear.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0, 3'd0, 3'd0, 1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd6, 3'd0, 3'd0, 1'b1, 1'b1, 32'h0001_0001);
        step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h0);
        idle(5, 1'b0, 1'b0);

        // Random traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic        r, w, rd;
            logic [31:0] wd, nxt, smp;
            logic [4:0]  tg;
            logic [2:0]  se, sd;
            r  = ($urandom_range(0, 24) == 0);
            w  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 1) == 1);
            wd = $urandom;
            tg = 5'($urandom_range(0, 31));
            se = 3'($urandom_range(0, 7));
            sd = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            nxt = r ? 32'd0 : model_next(w, wd, se, sd);
            smp = BYP ? model_next(w, wd, se, sd) : model_reg;
            step(r, w, wd, rd, tg, se, sd, nxt[16], nxt[0], smp);
        end
        idle(4, model_reg[16], model_reg[0]);

        chk("drain_q1", 32'(exp_q1.size()), 32'd0);
        chk("drain_q3", 32'(exp_q3.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
